// File: rtl/hist_pkg.sv
// Shared definitions for the ping-pong histogram block: default widths, bin count, saturating add, readout states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hist_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int CNT_W_DEF = 21;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  function automatic int num_bins(input int pix_w);
    return 1 << pix_w;
  endfunction

  // a + b clamped to 2^w-1; callers zero-extend operands and size-cast the result (w <= 32)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] maxv;
    sum  = {1'b0, a} + {1'b0, b};
    maxv = (33'd1 << w) - 33'd1;
    return 32'((sum > maxv) ? maxv : sum);
  endfunction

endpackage

// File: rtl/hist_bank.sv
// One histogram counter bank: NUM_BINS saturating counters with increment, single clear and clear-all.
// Latency: combinational read port; increments and clears take effect on the next clk edge.
// Backpressure: none, every port acts unconditionally in the cycle it is enabled.
// Ports: clk/rst; inc_en/inc_addr bump one bin; rd_addr/rd_data comb read;
//        clr_en/clr_addr zero one bin; clr_all zeroes every bin (wins over everything).
module hist_bank import hist_pkg::*; #(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [PIX_W-1:0] inc_addr,
  input  logic [PIX_W-1:0] rd_addr,
  output logic [CNT_W-1:0] rd_data,
  input  logic             clr_en,
  input  logic [PIX_W-1:0] clr_addr,
  input  logic             clr_all
);

  localparam int NUM_BINS = num_bins(PIX_W);

  logic [CNT_W-1:0] mem [NUM_BINS];

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BINS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BINS; i++) begin
        if (clr_all || (clr_en && clr_addr == PIX_W'(i))) begin
          mem[i] <= '0;
        end else if (inc_en && inc_addr == PIX_W'(i)) begin
          mem[i] <= CNT_W'(sat_add(32'(mem[i]), 32'd1, CNT_W));
        end
      end
    end
  end

endmodule

// File: rtl/hist_stat_pp.sv
// Ping-pong grey-level histogram: counts the current frame into one bank while the previous frame streams out of the other.
// Latency: hist_vld rises 1 cycle after the frame-end edge that swaps; one entry per accepted cycle.
// Backpressure: hist_ready stalls the readout only; pixel input never stalls, a frame ending mid-readout is dropped.
// Ports: clk/rst; pre_img_vsync (frame active), pre_img_hsync (pixel qualifier), pre_img_gray;
//        hist_ready in; hist_vld/hist_level/hist_cnt/hist_last entry out; frame_drop pulse out.
module hist_stat_pp import hist_pkg::*; #(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int CUM_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_img_vsync,
  input  logic             pre_img_hsync,
  input  logic [PIX_W-1:0] pre_img_gray,
  input  logic             hist_ready,
  output logic             hist_vld,
  output logic [PIX_W-1:0] hist_level,
  output logic [CNT_W-1:0] hist_cnt,
  output logic             hist_last,
  output logic             frame_drop
);

  logic             vsync_r;
  logic             wr_bank;
  rd_state_t        state;

  logic             eop;
  logic             accept;
  logic             finishing;
  logic             can_swap;
  logic             swap;
  logic             drop;
  logic [PIX_W-1:0] next_level;
  logic [PIX_W-1:0] rd_addr;
  logic             rd_sel;
  logic [CNT_W-1:0] bank_rd_data [2];
  logic [CNT_W-1:0] load_raw;
  logic [CNT_W-1:0] first_data;
  logic [CNT_W-1:0] next_cum;

  assign eop        = vsync_r & ~pre_img_vsync;
  assign accept     = hist_vld & hist_ready;
  assign finishing  = accept & hist_last;
  assign can_swap   = (state == IDLE) | finishing;
  assign swap       = eop & can_swap;
  assign drop       = eop & ~can_swap;
  assign next_level = hist_level + PIX_W'(1);

  // On a swap the first entry comes from the bank being closed; otherwise the
  // next entry is prefetched from the read bank so the output register can load it.
  assign rd_addr  = swap ? '0 : next_level;
  assign rd_sel   = swap ? wr_bank : ~wr_bank;
  assign load_raw = bank_rd_data[rd_sel];

  // A pixel in the eop cycle lands in the closing bank at the same edge that
  // loads entry 0, so bin 0 needs that increment forwarded.
  assign first_data = (pre_img_hsync && pre_img_gray == '0)
                      ? CNT_W'(sat_add(32'(load_raw), 32'd1, CNT_W)) : load_raw;
  assign next_cum   = CNT_W'(sat_add(32'(hist_cnt), 32'(load_raw), CNT_W));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    hist_bank #(
      .PIX_W (PIX_W),
      .CNT_W (CNT_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .inc_en   (pre_img_hsync && (wr_bank == 1'(b))),
      .inc_addr (pre_img_gray),
      .rd_addr  (rd_addr),
      .rd_data  (bank_rd_data[b]),
      .clr_en   (accept && (wr_bank != 1'(b))),
      .clr_addr (hist_level),
      .clr_all  (drop && (wr_bank == 1'(b)))
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_r    <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      vsync_r    <= pre_img_vsync;
      frame_drop <= drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      state      <= IDLE;
      hist_vld   <= 1'b0;
      hist_level <= '0;
      hist_cnt   <= '0;
      hist_last  <= 1'b0;
    end else if (swap) begin
      // also covers the back-to-back case where the last entry is accepted now
      wr_bank    <= ~wr_bank;
      state      <= STREAM;
      hist_vld   <= 1'b1;
      hist_level <= '0;
      hist_cnt   <= first_data;
      hist_last  <= 1'b0;
    end else if (accept) begin
      if (hist_last) begin
        state      <= IDLE;
        hist_vld   <= 1'b0;
        hist_level <= '0;
        hist_cnt   <= '0;
        hist_last  <= 1'b0;
      end else begin
        hist_level <= next_level;
        hist_cnt   <= (CUM_MODE != 0) ? next_cum : load_raw;
        hist_last  <= (next_level == '1);
      end
    end
  end

endmodule

// File: tb/tb_hist_stat_pp.sv
// Bench for hist_stat_pp: three instances (per-bin, cumulative, 4-bit per-bin) share one random stimulus.
// Latency: expected outputs come from a frame-level histogram model stepped once per clock.
// Backpressure: hist_ready patterns are held high, toggled, held low or random.
module tb_hist_stat_pp;

  logic       clk;
  logic       rst;
  logic       vs;
  logic       hs;
  logic [7:0] gray;
  logic       ready;

  logic [2:0]  vld;
  logic [2:0]  last;
  logic [2:0]  drop;
  logic [7:0]  lvl [3];
  logic [20:0] cnt0;
  logic [20:0] cnt1;
  logic [3:0]  cnt2;

  hist_stat_pp #(.PIX_W(8), .CNT_W(21), .CUM_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_gray(gray),
    .hist_ready(ready), .hist_vld(vld[0]), .hist_level(lvl[0]), .hist_cnt(cnt0),
    .hist_last(last[0]), .frame_drop(drop[0]));

  hist_stat_pp #(.PIX_W(8), .CNT_W(21), .CUM_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_gray(gray),
    .hist_ready(ready), .hist_vld(vld[1]), .hist_level(lvl[1]), .hist_cnt(cnt1),
    .hist_last(last[1]), .frame_drop(drop[1]));

  hist_stat_pp #(.PIX_W(8), .CNT_W(4), .CUM_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_gray(gray),
    .hist_ready(ready), .hist_vld(vld[2]), .hist_level(lvl[2]), .hist_cnt(cnt2),
    .hist_last(last[2]), .frame_drop(drop[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int  cur     [256];   // histogram of the frame being captured
  int  rd_hist [256];   // histogram of the frame being streamed
  bit  m_vld;
  int  m_k;
  bit  m_drop;
  bit  m_vsync_r;
  int  ready_mode;      // 0 high, 1 toggle, 2 low, 3 random
  bit  tog;
  byte unsigned pix_q [$];

  task automatic model_reset();
    cur       = '{default: 0};
    rd_hist   = '{default: 0};
    m_vld     = 1'b0;
    m_k       = 0;
    m_drop    = 1'b0;
    m_vsync_r = 1'b0;
  endtask

  function automatic int exp_cnt(input int d);
    longint mx;
    longint s;
    mx = (d == 2) ? 15 : ((1 << 21) - 1);
    s  = 0;
    if (d == 1) begin
      for (int j = 0; j <= m_k; j++) s += (rd_hist[j] > mx) ? mx : rd_hist[j];
    end else begin
      s = rd_hist[m_k];
    end
    return int'((s > mx) ? mx : s);
  endfunction

  function automatic logic [31:0] dut_cnt(input int d);
    case (d)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic check_outputs();
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("d%0d_vld", d), 32'(vld[d]), 32'(m_vld));
      check_eq($sformatf("d%0d_drop", d), 32'(drop[d]), 32'(m_drop));
      if (m_vld) begin
        check_eq($sformatf("d%0d_level", d), 32'(lvl[d]), 32'(m_k));
        check_eq($sformatf("d%0d_last@%0d", d, m_k), 32'(last[d]), 32'(m_k == 255));
        check_eq($sformatf("d%0d_cnt@%0d", d, m_k), dut_cnt(d), 32'(exp_cnt(d)));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s_d%0d_vld", tag, d), 32'(vld[d]), 32'd0);
      check_eq($sformatf("%s_d%0d_level", tag, d), 32'(lvl[d]), 32'd0);
      check_eq($sformatf("%s_d%0d_cnt", tag, d), dut_cnt(d), 32'd0);
      check_eq($sformatf("%s_d%0d_last", tag, d), 32'(last[d]), 32'd0);
      check_eq($sformatf("%s_d%0d_drop", tag, d), 32'(drop[d]), 32'd0);
    end
  endtask

  // One clock: drive inputs at negedge, advance the model, check at the next negedge.
  task automatic cycle(input logic v, input logic h, input logic [7:0] g);
    logic r;
    bit   acc;
    bit   fin;
    bit   eop;
    bit   was_vld;
    case (ready_mode)
      0:       r = 1'b1;
      1:       begin r = tog; tog = ~tog; end
      2:       r = 1'b0;
      default: r = 1'($urandom_range(0, 1));
    endcase
    vs = v; hs = h; gray = g; ready = r;

    was_vld = m_vld;
    acc     = m_vld && r;
    fin     = acc && (m_k == 255);
    eop     = m_vsync_r && !v;
    if (h) cur[g]++;
    if (acc) begin
      if (fin) m_vld = 1'b0;
      else     m_k++;
    end
    m_drop = 1'b0;
    if (eop) begin
      if (!was_vld || fin) begin
        rd_hist = cur;
        m_vld   = 1'b1;
        m_k     = 0;
      end else begin
        m_drop = 1'b1;
      end
      cur = '{default: 0};
    end
    m_vsync_r = v;

    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0);
  endtask

  // Frame from pix_q with random gaps; optionally the final pixel sits in the eop cycle.
  task automatic send_frame(input bit eop_pix);
    int n;
    n = pix_q.size();
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < n - (eop_pix ? 1 : 0); i++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b0, 8'd0);
      cycle(1'b1, 1'b1, pix_q[i]);
    end
    if (eop_pix && n > 0) cycle(1'b0, 1'b1, pix_q[n-1]);
    else                  cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic fill_const(input int n, input byte unsigned g);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(g);
  endtask

  task automatic fill_rand(input int n);
    byte unsigned hot [4];
    hot = '{8'd0, 8'd3, 8'd128, 8'd255};
    pix_q.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) pix_q.push_back(hot[$urandom_range(0, 3)]);
      else                           pix_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; hs = 1'b0; gray = 8'd0; ready = 1'b0;
    ready_mode = 0; tog = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 100 x grey 7 + 50 x grey 200, ready held high
    pix_q.delete();
    for (int i = 0; i < 150; i++) pix_q.push_back((i % 3 == 2) ? 8'd200 : 8'd7);
    send_frame(1'b0);
    idle(300);

    // ready toggling, then a 10 x grey 0 frame with its last pixel on the eop cycle
    ready_mode = 1;
    fill_rand(200);
    send_frame(1'b0);
    idle(600);
    fill_const(10, 8'd0);
    send_frame(1'b1);
    idle(600);

    // 20 x grey 3 saturates the 4-bit instance
    ready_mode = 0;
    fill_const(20, 8'd3);
    send_frame(1'b0);
    idle(300);

    // stalled readout: frame 2 is dropped, frame 1 survives, frame 3 starts clean
    ready_mode = 2;
    fill_rand(60);
    send_frame(1'b0);
    idle(5);
    fill_rand(40);
    send_frame(1'b1);
    idle(10);
    ready_mode = 0;
    idle(300);
    fill_rand(30);
    send_frame(1'b0);
    idle(300);

    // back-to-back: next eop lands on the cycle that accepts the last entry
    fill_rand(20);
    send_frame(1'b0);
    for (int i = 0; i < 255; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    cycle(1'b0, 1'b0, 8'd0);
    idle(300);

    // random ready with frequent frames (mix of swaps and drops)
    ready_mode = 3;
    for (int f = 0; f < 6; f++) begin
      fill_rand($urandom_range(20, 120));
      send_frame(1'($urandom_range(0, 1)));
      idle($urandom_range(0, 200));
    end
    ready_mode = 0;
    idle(300);

    // reset in the middle of a readout at level 40
    fill_rand(80);
    send_frame(1'b0);
    for (int i = 0; i < 2000 && !(m_vld && m_k == 40); i++) cycle(1'b0, 1'b0, 8'd0);
    check_eq("reach_level40", 32'(lvl[0]), 32'd40);
    rst = 1'b1;
    vs = 1'b0; hs = 1'b0;
    model_reset();
    #1;
    check_zero("midrst_async");
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    fill_const(5, 8'd1);
    send_frame(1'b0);
    idle(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
